muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the EXE-stage multiply/divide resource; sole owner of the HI/LO registers.
//  Accepts one mult/multu/div/divu/mthi/mtlo request at a time over a valid/ready handshake.
//  Runs a fixed-latency multiplier or a 32-iteration restoring divider, then writes HI/LO.
//  busy lets the stage stall mfhi/mflo until the write lands; flush aborts on pipeline cancel.
// PARAMETERS
//  MUL_STAGES  2  cycles spent in MUL state before HI/LO write; legal range >=1
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   controller can accept; transfer = req_valid && req_ready
//  req_op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved
//  req_src1   in   32  rs value / dividend / mthi-mtlo data
//  req_src2   in   32  rt value / divisor
//  flush      in   1   abort in-flight op, block acceptance this cycle
//  done       out  1   1-cycle pulse; hi/lo already show the new value in that cycle
//  busy       out  1   op in flight (state != IDLE)
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  Reset: clk and reset (synchronous, active-high) as above.
//   state=IDLE, hi=lo=0, done=0, busy=0; req_ready=0 while reset is high.
//  req_ready = (state==IDLE) && !flush && !reset (combinational).
//  Operand capture:
//   src1/src2/op are latched at transfer; later input changes have no effect.
//  FSM states: IDLE, MUL, DIV, FIX. Transfer in cycle T:
//   mthi/mtlo: stay IDLE; hi (or lo) <= src1 at end of T; done=1 in T+1.
//    Back-to-back transfers are allowed.
//   mult/multu: MUL in T+1..T+MUL_STAGES.
//    {hi,lo} <= 64-bit signed/unsigned product at end of T+MUL_STAGES.
//    done=1 in T+MUL_STAGES+1, state IDLE.
//   div/divu: DIV in T+1..T+32, 5-bit counter 0..31.
//    One restoring step per cycle on |src1|,|src2| (raw values for divu).
//    FIX in T+33: sign fixup, lo <= quotient, hi <= remainder.
//    done=1 in T+34, state IDLE.
//   reserved op: accepted, stays IDLE, no HI/LO change, no done.
//  Sign rules (div):
//   Quotient is negated iff operand signs differ.
//   Remainder takes the sign of the dividend.
//   Results are 32-bit two's complement, truncated.
//  Divide by zero (div and divu): lo=32'hFFFFFFFF, hi=src1 unmodified, same latency.
//  Overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
//  flush (takes priority over everything except reset):
//   Any state goes to IDLE at the next edge; the pending HI/LO write is suppressed.
//   This includes flush in FIX or in the last MUL cycle. done stays 0.
//   A request in the flush cycle is not accepted.
//  A done pulse already registered from the prior cycle is still emitted.
//  reset mid-operation: identical to reset at power-up; hi/lo are cleared.
//  busy=1 in every MUL/DIV/FIX cycle, and 0 in the done cycle.
//  No two ops overlap; HI/LO are written only at the points listed above.
// TESTING
//  1 mult -3 x 5, MUL_STAGES=2, transfer at T
//    -> hi=FFFFFFFF, lo=FFFFFFF1; done only at T+3; busy T+1..T+2.
//  2 divu 100/7 -> lo=0000000E, hi=00000002, done at T+34.
//    div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  3 div 5/0 -> lo=FFFFFFFF, hi=00000005.
//    div 80000000/FFFFFFFF -> lo=80000000, hi=00000000.
//  4 div with flush=1 at T+10 -> no done; hi/lo unchanged.
//    req_ready=1 at T+11; new mthi accepted at T+11 -> done at T+12.
//  5 mthi 0x1234 at T, mtlo 0x5678 at T+1 -> hi=1234 at T+1, lo=5678 at T+2.
//    done pulses in T+1 and T+2.
//  6 reset asserted mid-div (T+20) -> hi=lo=0, busy=0, done=0, no done afterwards.
//    req_valid held during busy is not accepted until IDLE.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EXE-stage multiply/divide sequencer owning HI/LO.
// Fixed-latency multiplier, 32-step restoring divider, mthi/mtlo, flush abort.
module muldiv_ctrl #(
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        done,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] mcnt_q, mcnt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic        xfer, div_sgn, q_neg, r_neg;
    logic [31:0] dvs;
    logic [32:0] rs, diff;
    logic [63:0] ea, eb, prod;

    assign req_ready = (state_q == IDLE) && !flush && !reset;
    assign xfer      = req_valid && req_ready;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Signed ops work on magnitudes; the quotient register starts as |dividend|.
    assign div_sgn = op_q == 3'd2;
    assign dvs     = (div_sgn && b_q[31]) ? -b_q : b_q;
    assign rs      = {rem_q, quo_q[31]};
    assign diff    = rs - {1'b0, dvs};
    assign q_neg   = div_sgn && (a_q[31] ^ b_q[31]);
    assign r_neg   = div_sgn && a_q[31];
    assign ea      = {{32{~op_q[0] & a_q[31]}}, a_q};
    assign eb      = {{32{~op_q[0] & b_q[31]}}, b_q};
    assign prod    = ea * eb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcnt_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcnt_q  <= mcnt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcnt_d  = mcnt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (xfer) begin
                    op_d   = req_op;
                    a_d    = req_src1;
                    b_d    = req_src2;
                    rem_d  = '0;
                    quo_d  = (req_op == 3'd2 && req_src1[31]) ? -req_src1 : req_src1;
                    mcnt_d = '0;
                    cnt_d  = '0;
                    case (req_op)
                        3'd0, 3'd1: state_d = MUL;
                        3'd2, 3'd3: state_d = DIV;
                        3'd4: begin
                            hi_d   = req_src1;
                            done_d = 1'b1;
                        end
                        3'd5: begin
                            lo_d   = req_src1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MUL: begin
                    if (mcnt_q == 32'(MUL_STAGES - 1)) begin
                        {hi_d, lo_d} = prod;
                        state_d      = IDLE;
                        done_d       = 1'b1;
                    end else begin
                        mcnt_d = mcnt_q + 32'd1;
                    end
                end
                DIV: begin
                    rem_d   = diff[32] ? rs[31:0] : diff[31:0];
                    quo_d   = {quo_q[30:0], ~diff[32]};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd31) ? FIX : DIV;
                end
                default: begin
                    lo_d    = (b_q == '0) ? '1 : (q_neg ? -quo_q : quo_q);
                    hi_d    = (b_q == '0) ? a_q : (r_neg ? -rem_q : rem_q);
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl with directed vectors.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        flush = 1'b0;
    logic        done, busy;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_ctrl #(.MUL_STAGES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .done(done), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cyc", 32'(cyc), 32'(e.cyc));
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Presents a request, waits (bounded) for acceptance, returns transfer cycle.
    task automatic send(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        output int t);
        int k = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = s1;
        req_src2  = s2;
        @(negedge clk);
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got ready=0 expected 1 (cyc %0d)", cyc);
        end
        t = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'd6;
        req_src1  = 32'hDEADBEEF;
        req_src2  = 32'h0BADF00D;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t, t2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        send(3'd0, 32'hFFFFFFFD, 32'd5, t);
        push(32'hFFFFFFFF, 32'hFFFFFFF1, t + 3);
        @(negedge clk);
        chk("mul_busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("mul_busy2", {31'd0, busy}, 32'd1);
        drain();
        send(3'd1, 32'hFFFFFFFF, 32'd2, t);
        push(32'd1, 32'hFFFFFFFE, t + 3);
        drain();

        send(3'd3, 32'd100, 32'd7, t);
        push(32'd2, 32'd14, t + 34);
        drain();
        send(3'd2, 32'hFFFFFFF9, 32'd2, t);
        push(32'hFFFFFFFF, 32'hFFFFFFFD, t + 34);
        drain();
        send(3'd2, 32'd7, 32'hFFFFFFFE, t);
        push(32'd1, 32'hFFFFFFFD, t + 34);
        drain();
        send(3'd2, 32'd5, 32'd0, t);
        push(32'd5, 32'hFFFFFFFF, t + 34);
        drain();
        send(3'd2, 32'hFFFFFFF8, 32'd0, t);
        push(32'hFFFFFFF8, 32'hFFFFFFFF, t + 34);
        drain();
        send(3'd3, 32'd7, 32'd0, t);
        push(32'd7, 32'hFFFFFFFF, t + 34);
        drain();
        send(3'd2, 32'h80000000, 32'hFFFFFFFF, t);
        push(32'd0, 32'h80000000, t + 34);
        drain();

        // Flush mid-divide, then immediate mthi.
        send(3'd2, 32'd100, 32'd3, t);
        wait_cyc(t + 10);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'h80000000);
        send(3'd4, 32'h0000CAFE, 32'd0, t2);
        chk("flush_accept_cyc", 32'(t2), 32'(t + 11));
        push(32'h0000CAFE, 32'h80000000, t2 + 1);
        drain();

        // Flush in last MUL cycle and in FIX.
        send(3'd0, 32'd3, 32'd3, t);
        wait_cyc(t + 2);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mflush_hi", hi, 32'h0000CAFE);
        chk("mflush_lo", lo, 32'h80000000);
        send(3'd3, 32'd9, 32'd3, t);
        wait_cyc(t + 33);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fixflush_hi", hi, 32'h0000CAFE);
        chk("fixflush_lo", lo, 32'h80000000);
        chk("fixflush_busy", {31'd0, busy}, 32'd0);

        // Back-to-back mthi/mtlo.
        send(3'd4, 32'h00001234, 32'd0, t);
        push(32'h00001234, 32'h80000000, t + 1);
        send(3'd5, 32'h00005678, 32'd0, t2);
        chk("b2b_cyc", 32'(t2), 32'(t + 1));
        push(32'h00001234, 32'h00005678, t2 + 1);
        drain();

        // Reserved op: accepted, no effect.
        send(3'd6, 32'h11111111, 32'h22222222, t);
        repeat (4) @(posedge clk);
        #1;
        chk("rsv_hi", hi, 32'h00001234);
        chk("rsv_lo", lo, 32'h00005678);

        // Request held during busy is taken only once IDLE.
        send(3'd1, 32'd6, 32'd7, t);
        push(32'd0, 32'd42, t + 3);
        send(3'd4, 32'h00000099, 32'd0, t2);
        chk("held_accept_cyc", 32'(t2), 32'(t + 3));
        push(32'h00000099, 32'd42, t2 + 1);
        drain();

        // Reset mid-divide.
        send(3'd3, 32'd1000, 32'd9, t);
        wait_cyc(t + 20);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
